instr_decode_stage: RTL and testbench

//  Registered RV32I/RV64I decode stage between fetch and execute. Classifies the opcode into an

---
 rtl/instr_decode_stage.sv | 193 +++++++++++++++++++
 tb/tb_instr_decode_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : instr_decode_stage
// Brief    : Registered RV32I/RV64I decode stage with valid/ready handshake,
//            optional 2-entry skid buffer, flush and saturating illegal counter.
// Revision : 1.0
// ============================================================================
module instr_decode_stage #(
    parameter int XLEN        = 32,
    parameter int ENABLE_SKID = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_fmt,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam logic [2:0] c_FMT_R   = 3'd0;
    localparam logic [2:0] c_FMT_I   = 3'd1;
    localparam logic [2:0] c_FMT_S   = 3'd2;
    localparam logic [2:0] c_FMT_B   = 3'd3;
    localparam logic [2:0] c_FMT_U   = 3'd4;
    localparam logic [2:0] c_FMT_J   = 3'd5;
    localparam logic [2:0] c_FMT_ILL = 3'd7;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      fmt;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } payload_t;

    logic [2:0]       w_fmt;
    logic [31:0]      w_imm32;
    logic [XLEN-1:0]  w_imm;
    payload_t         w_dec;
    payload_t         r_out;
    payload_t         r_skid;
    state_t           r_state;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_cnt;
    logic             w_in_fire;
    logic             w_out_fire;

    always_comb begin
        w_fmt = c_FMT_ILL;
        case (in_instr[6:0])
            7'b0110111, 7'b0010111: w_fmt = c_FMT_U;
            7'b1101111:             w_fmt = c_FMT_J;
            7'b1100111:             w_fmt = (in_instr[14:12] == 3'b000) ? c_FMT_I : c_FMT_ILL;
            7'b0000011, 7'b0010011: w_fmt = c_FMT_I;
            7'b1100011:             w_fmt = c_FMT_B;
            7'b0100011:             w_fmt = c_FMT_S;
            7'b0110011:             w_fmt = c_FMT_R;
            default:                w_fmt = c_FMT_ILL;
        endcase
    end

    always_comb begin
        w_imm32 = '0;
        case (w_fmt)
            c_FMT_I: w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            c_FMT_S: w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            c_FMT_B: w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0};
            c_FMT_U: w_imm32 = {in_instr[31:12], 12'b0};
            c_FMT_J: w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                in_instr[20], in_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    generate
        if (XLEN > 32) begin : g_imm_wide
            assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_imm_narrow
            assign w_imm = w_imm32[XLEN-1:0];
        end
    endgenerate

    always_comb begin
        w_dec         = '0;
        w_dec.pc      = in_pc;
        w_dec.opcode  = in_instr[6:0];
        w_dec.fmt     = w_fmt;
        w_dec.rd      = in_instr[11:7];
        w_dec.rs1     = in_instr[19:15];
        w_dec.rs2     = in_instr[24:20];
        w_dec.funct3  = in_instr[14:12];
        w_dec.funct7  = in_instr[31:25];
        w_dec.imm     = w_imm;
        w_dec.illegal = (w_fmt == c_FMT_ILL);
    end

    // Skid variant takes in_ready from a register; single-entry variant looks through to out_ready.
    assign in_ready   = ((ENABLE_SKID != 0) ? r_in_ready : (~out_valid | out_ready)) & ~flush & ~rst;
    assign out_valid  = (r_state != S_EMPTY);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_out      <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
            r_cnt      <= '0;
        end else begin
            if (w_out_fire && r_out.illegal && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (flush) begin
                r_state    <= S_EMPTY;
                r_in_ready <= 1'b1;
            end else begin
                case (r_state)
                    S_EMPTY: begin
                        if (w_in_fire) begin
                            r_out   <= w_dec;
                            r_state <= S_ONE;
                        end
                    end
                    S_ONE: begin
                        if (w_in_fire) begin
                            if (out_ready) begin
                                r_out <= w_dec;
                            end else begin
                                r_skid     <= w_dec;
                                r_state    <= S_TWO;
                                r_in_ready <= 1'b0;
                            end
                        end else if (out_ready) begin
                            r_state <= S_EMPTY;
                        end
                    end
                    S_TWO: begin
                        if (out_ready) begin
                            r_out      <= r_skid;
                            r_state    <= S_ONE;
                            r_in_ready <= 1'b1;
                        end
                    end
                    default: begin
                        r_state    <= S_EMPTY;
                        r_in_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign out_pc      = r_out.pc;
    assign out_opcode  = r_out.opcode;
    assign out_fmt     = r_out.fmt;
    assign out_rd      = r_out.rd;
    assign out_rs1     = r_out.rs1;
    assign out_rs2     = r_out.rs2;
    assign out_funct3  = r_out.funct3;
    assign out_funct7  = r_out.funct7;
    assign out_imm     = r_out.imm;
    assign out_illegal = r_out.illegal;
    assign illegal_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_decode_stage
// Brief    : Scoreboard bench for instr_decode_stage: RV64 skid instance and
//            RV32 single-entry instance against a behavioural decode model.
// Revision : 1.0
// ============================================================================
module tb_instr_decode_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic flush = 1'b0;

    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_out_illegal;
    logic [31:0] a_in_instr = '0;
    logic [63:0] a_in_pc = '0, a_out_pc, a_out_imm;
    logic [6:0]  a_out_opcode, a_out_funct7;
    logic [2:0]  a_out_fmt, a_out_funct3;
    logic [4:0]  a_out_rd, a_out_rs1, a_out_rs2;
    logic [3:0]  a_cnt;

    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_out_illegal;
    logic [31:0] b_in_instr = '0;
    logic [31:0] b_in_pc = '0, b_out_pc, b_out_imm;
    logic [6:0]  b_out_opcode, b_out_funct7;
    logic [2:0]  b_out_fmt, b_out_funct3;
    logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2;
    logic [15:0] b_cnt;

    instr_decode_stage #(.XLEN(64), .ENABLE_SKID(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_pc(a_in_pc),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc),
        .out_opcode(a_out_opcode), .out_fmt(a_out_fmt), .out_rd(a_out_rd),
        .out_rs1(a_out_rs1), .out_rs2(a_out_rs2), .out_funct3(a_out_funct3),
        .out_funct7(a_out_funct7), .out_imm(a_out_imm), .out_illegal(a_out_illegal),
        .illegal_cnt(a_cnt)
    );

    instr_decode_stage #(.XLEN(32), .ENABLE_SKID(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
        .out_opcode(b_out_opcode), .out_fmt(b_out_fmt), .out_rd(b_out_rd),
        .out_rs1(b_out_rs1), .out_rs2(b_out_rs2), .out_funct3(b_out_funct3),
        .out_funct7(b_out_funct7), .out_imm(b_out_imm), .out_illegal(b_out_illegal),
        .illegal_cnt(b_cnt)
    );

    typedef struct {
        logic [63:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  fmt;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic        ill;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   cnt_a = 0;
    int   cnt_b = 0;
    bit   mon_en = 1'b0;
    bit   a_took = 1'b0, b_took = 1'b0;
    int   a_dir = 5, b_dir = 5;
    int   vmode = 0, a_rmode = 0, b_rmode = 0;
    bit   rnd_flush = 1'b0;

    // Known-answer instructions: addi x1,x0,-1 / beq x0,x0,-4 / lui x1,0x80000 / zero word / jalr funct3=1
    logic [31:0] dir_instr [5] = '{32'hFFF00093, 32'hFE000EE3, 32'h800000B7, 32'h00000000, 32'h00001067};
    logic [2:0]  dir_fmt   [5] = '{3'd1, 3'd3, 3'd4, 3'd7, 3'd7};
    logic [63:0] dir_imm   [5] = '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFC,
                                   64'hFFFFFFFF_80000000, 64'h0, 64'h0};

    task automatic check(string name, logic [191:0] act, logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t model(logic [31:0] w, logic [63:0] pc);
        exp_t   e;
        longint s;
        longint sgn;
        e.pc = pc; e.opcode = w[6:0]; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
        e.f3 = w[14:12]; e.f7 = w[31:25];
        case (w[6:0])
            7'h37, 7'h17: e.fmt = 3'd4;
            7'h6F:        e.fmt = 3'd5;
            7'h67:        e.fmt = (w[14:12] == 3'd0) ? 3'd1 : 3'd7;
            7'h03, 7'h13: e.fmt = 3'd1;
            7'h63:        e.fmt = 3'd3;
            7'h23:        e.fmt = 3'd2;
            7'h33:        e.fmt = 3'd0;
            default:      e.fmt = 3'd7;
        endcase
        sgn = w[31] ? 64'sd1 : 64'sd0;
        case (e.fmt)
            3'd1: s = longint'(w[31:20]) - sgn * 4096;
            3'd2: s = longint'(w[31:25]) * 32 + longint'(w[11:7]) - sgn * 4096;
            3'd3: s = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2 - sgn * 4096;
            3'd4: s = longint'(w[31:12]) * 4096 - sgn * 64'sh1_0000_0000;
            3'd5: s = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2
                      - sgn * 64'sd1048576;
            default: s = 0;
        endcase
        e.imm = s;
        e.ill = (e.fmt == 3'd7);
        return e;
    endfunction

    function automatic exp_t mk(logic [31:0] w, logic [63:0] pc);
        exp_t e;
        e = model(w, pc);
        for (int k = 0; k < 5; k++) begin
            if (w == dir_instr[k]) begin
                e.fmt = dir_fmt[k];
                e.imm = dir_imm[k];
                e.ill = (dir_fmt[k] == 3'd7);
            end
        end
        return e;
    endfunction

    function automatic logic [191:0] pk(exp_t e, bit narrow);
        logic [63:0] pc;
        logic [63:0] imm;
        pc  = narrow ? {32'b0, e.pc[31:0]}  : e.pc;
        imm = narrow ? {32'b0, e.imm[31:0]} : e.imm;
        return {28'b0, pc, e.opcode, e.fmt, e.rd, e.rs1, e.rs2, e.f3, e.f7, imm, e.ill};
    endfunction

    function automatic logic [191:0] act_a();
        return {28'b0, a_out_pc, a_out_opcode, a_out_fmt, a_out_rd, a_out_rs1, a_out_rs2,
                a_out_funct3, a_out_funct7, a_out_imm, a_out_illegal};
    endfunction

    function automatic logic [191:0] act_b();
        return {28'b0, 32'b0, b_out_pc, b_out_opcode, b_out_fmt, b_out_rd, b_out_rs1, b_out_rs2,
                b_out_funct3, b_out_funct7, 32'b0, b_out_imm, b_out_illegal};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [9];
        logic [31:0] w;
        int          r;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h63, 7'h23, 7'h33};
        w = $urandom;
        r = $urandom_range(0, 9);
        if (r < 7) w[6:0] = ops[$urandom_range(0, 8)];
        else if (r == 7) w = '0;
        return w;
    endfunction

    // Monitor: compares handshake flags, counter and popped payloads at each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("a_out_valid", a_out_valid, qa.size() != 0);
                check("a_in_ready", a_in_ready, (qa.size() < 2) && !flush && !rst);
                check("a_illegal_cnt", a_cnt, cnt_a);
                if (a_out_valid && a_out_ready && qa.size() > 0) begin
                    e = qa.pop_front();
                    check("a_payload", act_a(), pk(e, 1'b0));
                    if (e.ill && cnt_a < 15) cnt_a++;
                end
                check("b_out_valid", b_out_valid, qb.size() != 0);
                check("b_in_ready", b_in_ready, ((qb.size() == 0) || b_out_ready) && !flush && !rst);
                check("b_illegal_cnt", b_cnt, cnt_b);
                if (b_out_valid && b_out_ready && qb.size() > 0) begin
                    e = qb.pop_front();
                    check("b_payload", act_b(), pk(e, 1'b1));
                    if (e.ill && cnt_b < 65535) cnt_b++;
                end
            end
        end
    end

    task automatic step(bit r, bit f);
        @(posedge clk);
        #1;
        rst   = r;
        flush = f || (rnd_flush && ($urandom_range(0, 99) < 3));
        if (!a_in_valid || a_took) begin
            if (a_dir < 5) begin a_in_valid = 1'b1; a_in_instr = dir_instr[a_dir]; a_dir++; end
            else begin
                a_in_valid = (vmode == 2) ? ($urandom_range(0, 99) < 75) : (vmode == 1);
                a_in_instr = rand_instr();
            end
            a_in_pc = {$urandom, $urandom};
        end
        if (!b_in_valid || b_took) begin
            if (b_dir < 5) begin b_in_valid = 1'b1; b_in_instr = dir_instr[b_dir]; b_dir++; end
            else begin
                b_in_valid = (vmode == 2) ? ($urandom_range(0, 99) < 75) : (vmode == 1);
                b_in_instr = rand_instr();
            end
            b_in_pc = $urandom;
        end
        if (vmode == 0) begin a_in_valid = 1'b0; b_in_valid = 1'b0; end
        a_out_ready = (a_rmode == 2) ? ($urandom_range(0, 99) < 60) : (a_rmode == 1);
        b_out_ready = (b_rmode == 2) ? ($urandom_range(0, 99) < 60) : (b_rmode == 1);
        @(negedge clk);
        #1;
        a_took = a_in_valid && a_in_ready;
        b_took = b_in_valid && b_in_ready;
        if (a_took) qa.push_back(mk(a_in_instr, a_in_pc));
        if (b_took) qb.push_back(mk(b_in_instr, {32'b0, b_in_pc}));
        if (rst || flush) begin qa.delete(); qb.delete(); end
        if (rst) begin cnt_a = 0; cnt_b = 0; end
    endtask

    initial begin
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("reset_a_payload", act_a(), '0);
        check("reset_b_payload", act_b(), '0);
        check("reset_a_out_valid", a_out_valid, 1'b0);
        check("reset_b_out_valid", b_out_valid, 1'b0);
        check("reset_a_in_ready", a_in_ready, 1'b0);
        check("reset_a_cnt", a_cnt, '0);
        mon_en = 1'b1;

        // Known-answer stream; A stalls three cycles so it fills its skid buffer.
        a_dir = 0; b_dir = 0; vmode = 1; a_rmode = 0; b_rmode = 1;
        repeat (3) step(1'b0, 1'b0);
        a_rmode = 1;
        repeat (8) step(1'b0, 1'b0);

        // Fill A to two entries, then flush; afterwards fill again and reset.
        a_rmode = 0;
        repeat (3) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        vmode = 2; a_rmode = 2; b_rmode = 2;
        repeat (3) step(1'b0, 1'b0);

        rnd_flush = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(0, 999) < 2), 1'b0);
        end

        rnd_flush = 1'b0; vmode = 0; a_rmode = 1; b_rmode = 1;
        repeat (6) step(1'b0, 1'b0);
        check("a_drained", qa.size(), 0);
        check("b_drained", qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
